// File: rtl/reg_share_arb.sv
// Two-requester round-robin arbiter guarding one shared register; each grant allows up to HOLD writes, followed by one release cycle.
// Optional write statistics counter: define REG_SHARE_STATS_EN to add the wr_cnt output.
module reg_share_arb #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic             last
`ifdef REG_SHARE_STATS_EN
  ,
  output logic [7:0]       wr_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, REL = 2'd3} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             last_wr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_dat;

  assign last_wr = (cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: if (!req0 || last_wr) state_nxt = REL;
      GNT1: if (!req1 || last_wr) state_nxt = REL;
      REL:  state_nxt = IDLE;
    endcase
  end

  // Grants decode straight from the state flops, so they change only at clock edges.
  always_comb begin
    gnt0   = (state == GNT0);
    gnt1   = (state == GNT1);
    wr_en  = (gnt0 && req0) || (gnt1 && req1);
    wr_dat = gnt1 ? d1 : d0;
  end

  // Grants are entered only from IDLE, so clearing in IDLE is the clear-on-entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      last <= 1'b1;
    end else begin
      if (wr_en) begin
        q <= wr_dat;
      end
      if (state == IDLE) begin
        cnt <= '0;
      end else if (wr_en) begin
        cnt <= cnt + 4'd1;
      end
      if (state == IDLE && state_nxt == GNT0) begin
        last <= 1'b0;
      end else if (state == IDLE && state_nxt == GNT1) begin
        last <= 1'b1;
      end
    end
  end

`ifdef REG_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else if (wr_en && wr_cnt != 8'hFF) begin
      wr_cnt <= wr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: directed scenarios with literal expectations plus randomized traffic against a transaction-level model.
module tb_reg_share_arb;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] d0 = '0;
  logic [7:0] d1 = '0;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] q;
  logic       last;
`ifdef REG_SHARE_STATS_EN
  logic [7:0] wr_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Model: who owns the register (-1 none), whether a release cycle is pending,
  // how many writes the current owner has done, and the visible register/last values.
  int       m_own;
  bit       m_rel;
  int       m_nw;
  int       m_wrs;
  bit [7:0] m_q;
  bit       m_last;

  always #5 clk = ~clk;

  reg_share_arb #(.WIDTH(8), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .d0    (d0),
    .req1  (req1),
    .d1    (d1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .q     (q),
    .last  (last)
`ifdef REG_SHARE_STATS_EN
    ,
    .wr_cnt(wr_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit r0, input bit [7:0] v0,
                            input bit r1, input bit [7:0] v1);
    bit my_req;
    if (!rst) begin
      m_own = -1; m_rel = 0; m_nw = 0; m_q = '0; m_last = 1; m_wrs = 0;
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_own < 0) begin
      if (r0 && r1) m_own = m_last ? 0 : 1;
      else if (r0)  m_own = 0;
      else if (r1)  m_own = 1;
      if (m_own >= 0) begin
        m_last = (m_own == 1);
        m_nw = 0;
      end
    end else begin
      my_req = (m_own == 0) ? r0 : r1;
      if (my_req) begin
        m_q = (m_own == 0) ? v0 : v1;
        m_nw++;
        if (m_wrs < 255) m_wrs++;
        if (m_nw == HOLD) begin
          m_own = -1; m_rel = 1;
        end
      end else begin
        m_own = -1; m_rel = 1;
      end
    end
  endtask

  // One clock: drive inputs, predict the post-edge state, then compare on the falling edge.
  task automatic step(input bit rst, input bit r0, input bit [7:0] v0,
                      input bit r1, input bit [7:0] v1);
    rst_n = rst; req0 = r0; d0 = v0; req1 = r1; d1 = v1;
    model_edge(rst, r0, v0, r1, v1);
    @(negedge clk);
    chk("model_gnt0", 32'(gnt0), 32'(m_own == 0));
    chk("model_gnt1", 32'(gnt1), 32'(m_own == 1));
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_last", 32'(last), 32'(m_last));
    chk("grants_exclusive", 32'(gnt0 & gnt1), 32'd0);
`ifdef REG_SHARE_STATS_EN
    chk("model_wr_cnt", 32'(wr_cnt), 32'(m_wrs));
`endif
  endtask

  initial begin
    // Reset held with both requests high.
    step(0, 1, 8'h11, 1, 8'h22);
    step(0, 1, 8'h11, 1, 8'h22);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_last", 32'(last), 32'd1);

    // Single requester, two writes then release, then re-grant.
    step(1, 1, 8'h00, 0, 8'h00);
    chk("single_gnt0_first", 32'(gnt0), 32'd1);
    chk("single_last", 32'(last), 32'd0);
    step(1, 1, 8'hA5, 0, 8'h00);
    chk("single_q_a5", 32'(q), 32'hA5);
    chk("single_gnt0_second", 32'(gnt0), 32'd1);
    step(1, 1, 8'h3C, 0, 8'h00);
    chk("single_q_3c", 32'(q), 32'h3C);
    chk("single_rel", 32'(gnt0), 32'd0);
    step(1, 1, 8'h77, 0, 8'h00);
    chk("single_idle_q_holds", 32'(q), 32'h3C);
    step(1, 1, 8'h77, 0, 8'h00);
    chk("single_regrant", 32'(gnt0), 32'd1);

    // Tie after reset: requester 0 first, then requester 1.
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 1, 8'h01, 1, 8'h81);
    chk("tie_first_gnt0", 32'(gnt0), 32'd1);
    step(1, 1, 8'h02, 1, 8'h82);
    chk("tie_q_d0", 32'(q), 32'h02);
    step(1, 1, 8'h03, 1, 8'h83);
    chk("tie_q_d0b", 32'(q), 32'h03);
    chk("tie_rel", 32'(gnt0 | gnt1), 32'd0);
    step(1, 1, 8'h04, 1, 8'h84);
    step(1, 1, 8'h05, 1, 8'h85);
    chk("tie_second_gnt1", 32'(gnt1), 32'd1);
    chk("tie_last1", 32'(last), 32'd1);
    step(1, 1, 8'h06, 1, 8'h86);
    chk("tie_q_d1", 32'(q), 32'h86);

    // Early drop during a grant to requester 1.
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 0, 8'h00, 1, 8'h00);
    step(1, 0, 8'h00, 1, 8'h55);
    chk("drop_q_55", 32'(q), 32'h55);
    chk("drop_gnt1", 32'(gnt1), 32'd1);
    step(1, 0, 8'h00, 0, 8'hAA);
    chk("drop_rel_q", 32'(q), 32'h55);
    chk("drop_rel_gnt1", 32'(gnt1), 32'd0);
    step(1, 0, 8'h00, 0, 8'hAA);
    chk("drop_idle_q", 32'(q), 32'h55);

    // Reset asserted in the middle of a grant: no write lands.
    step(1, 1, 8'h10, 0, 8'h00);
    chk("midrst_gnt0_before", 32'(gnt0), 32'd1);
    step(0, 1, 8'hFF, 0, 8'h00);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_gnt0", 32'(gnt0), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 3) != 0, 8'($urandom));
    end

`ifdef REG_SHARE_STATS_EN
    step(0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 700; i++) begin
      step(1, 1, 8'($urandom), 0, 8'h00);
    end
    chk("stats_saturate", 32'(wr_cnt), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
